t_ff_bank_counter: RTL and testbench

Parametrised bank of WIDTH toggle flip-flops with synchronous active-low reset, load, enable and a 2-bit mode select. Runs as a raw T-register bank (per-bit toggle mask), a modulo-MOD up counter, a modulo-MOD down counter, or holds. Emits a one-cycle terminal-count flag on wrap. Successor to the single T flip-flop cell. Used as the general counter/divider primitive in the lab designs.

---
 rtl/t_ff_pkg.sv | 11 +
 rtl/t_ff_cell.sv | 22 ++
 rtl/t_ff_bank_counter.sv | 105 ++++++++++
 tb/tb_t_ff_bank_counter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/t_ff_pkg.sv
// Shared definitions for the toggle flip-flop bank counter: mode select encoding.
package t_ff_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

endpackage

// File: rtl/t_ff_cell.sv
// Single toggle flip-flop: flips on a clock edge when t is high, synchronous
// active-low reset to a per-instance value.
module t_ff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val,
    input  logic t,
    output logic q,
    output logic qn
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= rst_val;
        end else if (t) begin
            q <= ~q;
        end
    end

    assign qn = ~q;

endmodule

// File: rtl/t_ff_bank_counter.sv
// Bank of WIDTH T flip-flops operating as a raw toggle register, modulo-MOD
// up/down counter or hold, with a registered terminal-count pulse on wrap.
module t_ff_bank_counter
    import t_ff_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MOD       = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc
);

    localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

    mode_e            mode_s;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] t_eff;
    logic             tc_next;
    logic             carry_up;
    logic             carry_dn;

    assign mode_s = mode_e'(mode);

    // Ripple toggle masks: bit i flips when all lower bits of q (up) or qn (down) are 1.
    always_comb begin
        up_t     = '0;
        dn_t     = '0;
        carry_up = 1'b1;
        carry_dn = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            up_t[i]  = carry_up;
            dn_t[i]  = carry_dn;
            carry_up = carry_up & q[i];
            carry_dn = carry_dn & qn[i];
        end
    end

    always_comb begin
        t_eff   = '0;
        tc_next = 1'b0;
        target  = load_val;
        if (load) begin
            if ((mode_s == MODE_UP || mode_s == MODE_DOWN) && ({1'b0, load_val} >= MOD_W)) begin
                target = MAX_VAL;
            end
            t_eff = q ^ target;
        end else if (en) begin
            unique case (mode_s)
                MODE_TOGGLE: t_eff = t_in;
                MODE_UP: begin
                    if (q >= MAX_VAL) begin
                        t_eff   = q;
                        tc_next = 1'b1;
                    end else begin
                        t_eff = up_t;
                    end
                end
                MODE_DOWN: begin
                    if (q == '0) begin
                        t_eff   = MAX_VAL;
                        tc_next = 1'b1;
                    end else if ({1'b0, q} >= MOD_W) begin
                        t_eff = q ^ MAX_VAL;
                    end else begin
                        t_eff = dn_t;
                    end
                end
                MODE_HOLD: t_eff = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tc <= 1'b0;
        end else begin
            tc <= tc_next;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_ff_cell u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .rst_val(RST_Q[i]),
            .t      (t_eff[i]),
            .q      (q[i]),
            .qn     (qn[i])
        );
    end

endmodule

// File: tb/tb_t_ff_bank_counter.sv
// Bench for t_ff_bank_counter: MOD=10 and MOD=16 instances driven in parallel,
// compared every cycle against an arithmetic reference model.
module tb_t_ff_bank_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] t_in;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] q_a, qn_a, q_b, qn_b;
    logic         tc_a, tc_b;

    int errors = 0;
    int checks = 0;
    int mq_a = 0, mq_b = 0;
    bit mtc_a = 0, mtc_b = 0;

    always #5 clk = ~clk;

    t_ff_bank_counter #(.WIDTH(W), .MOD(10), .RESET_VAL(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t_in(t_in),
        .load(load), .load_val(load_val), .q(q_a), .qn(qn_a), .tc(tc_a)
    );

    t_ff_bank_counter #(.WIDTH(W), .MOD(16), .RESET_VAL(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t_in(t_in),
        .load(load), .load_val(load_val), .q(q_b), .qn(qn_b), .tc(tc_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the counter's rules, using plain integers.
    task automatic model(input int modv, input int qin, output int qout, output bit tcout);
        int lv = int'(load_val);
        qout  = qin;
        tcout = 0;
        if (!rst_n) begin
            qout = 0;
        end else if (load) begin
            qout = ((mode == 2'd1 || mode == 2'd2) && lv >= modv) ? modv - 1 : lv;
        end else if (en) begin
            case (mode)
                2'd0: qout = qin ^ int'(t_in);
                2'd1: if (qin >= modv - 1) begin qout = 0; tcout = 1; end
                      else qout = qin + 1;
                2'd2: if (qin == 0) begin qout = modv - 1; tcout = 1; end
                      else if (qin >= modv) qout = modv - 1;
                      else qout = qin - 1;
                default: qout = qin;
            endcase
        end
    endtask

    task automatic step(input bit r, input bit ld, input int lv, input bit e,
                        input int m, input int t);
        int nq;
        bit ntc;
        rst_n = r; load = ld; load_val = W'(lv); en = e; mode = 2'(m); t_in = W'(t);
        model(10, mq_a, nq, ntc); mq_a = nq; mtc_a = ntc;
        model(16, mq_b, nq, ntc); mq_b = nq; mtc_b = ntc;
        @(posedge clk);
        #1;
        chk("q_mod10",  int'(q_a),  mq_a);
        chk("qn_mod10", int'(qn_a), (~mq_a) & 15);
        chk("tc_mod10", int'(tc_a), int'(mtc_a));
        chk("q_mod16",  int'(q_b),  mq_b);
        chk("qn_mod16", int'(qn_b), (~mq_b) & 15);
        chk("tc_mod16", int'(tc_b), int'(mtc_b));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; t_in = '0; load = 1'b0; load_val = '0;

        // Reset dominates load/enable
        step(0, 1, 7, 1, 1, 0);
        step(0, 1, 7, 1, 1, 0);
        chk("reset_q", int'(q_a), 0);
        chk("reset_qn", int'(qn_a), 15);
        step(1, 0, 0, 1, 1, 0);
        chk("first_up", int'(q_a), 1);

        // UP wrap from 0
        step(0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 0, 1, 1, 0);
            if (i == 10) begin
                chk("up_wrap_q", int'(q_a), 0);
                chk("up_wrap_tc", int'(tc_a), 1);
            end
        end

        // DOWN wrap and load clamp
        step(1, 1, 1, 1, 2, 0);
        step(1, 0, 0, 1, 2, 0);
        step(1, 0, 0, 1, 2, 0);
        chk("down_wrap_q", int'(q_a), 9);
        chk("down_wrap_tc", int'(tc_a), 1);
        step(1, 1, 14, 1, 2, 0);
        chk("load_clamp", int'(q_a), 9);
        chk("load_noclamp16", int'(q_b), 14);

        // TOGGLE, hold, priority
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 4'b1010);
        chk("toggle1", int'(q_a), 10);
        step(1, 0, 0, 1, 0, 4'b0011);
        chk("toggle2", int'(q_a), 9);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 4'b1111);
        chk("hold_q", int'(q_a), 9);
        step(1, 0, 0, 1, 3, 0);
        step(1, 0, 0, 1, 2, 0);
        chk("down_after_hold", int'(q_a), 8);
        step(1, 1, 5, 1, 1, 0);
        chk("load_beats_count", int'(q_a), 5);

        // Out-of-range recovery
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 4'b1101);
        step(1, 0, 0, 1, 1, 0);
        chk("oor_up_q", int'(q_a), 0);
        chk("oor_up_tc", int'(tc_a), 1);
        step(1, 0, 0, 1, 0, 4'b1101);
        step(1, 0, 0, 1, 2, 0);
        chk("oor_down_q", int'(q_a), 9);
        chk("oor_down_tc", int'(tc_a), 0);

        // Full-range modulus
        step(1, 1, 15, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        chk("m16_up_wrap_q", int'(q_b), 0);
        chk("m16_up_wrap_tc", int'(tc_b), 1);
        step(1, 0, 0, 1, 2, 0);
        chk("m16_down_wrap_q", int'(q_b), 15);
        chk("m16_down_wrap_tc", int'(tc_b), 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(31) != 0), ($urandom_range(7) == 0), int'($urandom_range(15)),
                 ($urandom_range(3) != 0), int'($urandom_range(3)), int'($urandom_range(15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
